flux_rr_scheduler: RTL
======================

// Module: flux_rr_scheduler
// PURPOSE
//  Shares one tagged write port (data + TAG_WIDTH-bit flux tag) between FLUX independent producers.
//  Sits in front of a multi-stream top_ms-style datapath input (e.g. in_port): picks one producer per
//  cycle, round-robin with burst quantum, and appends the winner's index as tag.
//  Honours the per-flux full vector returned by the datapath; a full flux never blocks the others.
// PARAMETERS
//  DATA_WIDTH  8  payload width per producer
//  FLUX        4  number of producers / tags; legal range 2..16
//  BURST       4  max consecutive beats granted to one producer before rotation; legal range 1..255
//  TAG_WIDTH   $clog2(FLUX)  localparam; not overridable
// PORTS
//  clk        in   1                      single clock; all state on rising edge
//  rst        in   1                      synchronous reset, active-low (0 = reset)
//  req_din    in   FLUX*DATA_WIDTH        producer i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_valid  in   FLUX                   producer i has a beat
//  req_ready  out  FLUX                   one-hot; beat i consumed this cycle
//  out_din    out  DATA_WIDTH+TAG_WIDTH   {tag, payload}; tag in MSBs
//  out_write  out  1                      write strobe to datapath write_interface
//  out_full   in   FLUX                   per-tag full from datapath
// BEHAVIOUR
//  - Eligible(i) = req_valid[i] & ~out_full[i]. Transfer on i  <=>  req_ready[i] = 1.
//  - Datapath is zero-latency (combinational grant); arbitration state is registered.
//  - out_write = |req_ready; out_din = {winner, req_din[winner]}; out_din is 0 when out_write = 0.
//  - req_ready is never asserted for a non-eligible producer; at most one bit is set.
//  - FSM state (flux_sched_pkg::state_t): IDLE, HOLD. Registers: ptr (TAG_WIDTH),
//    holder (TAG_WIDTH), cnt (8 bit).
//  - IDLE: winner = first eligible index scanning ptr, ptr+1, ... modulo FLUX.
//    With a winner: go to HOLD, holder = winner, cnt = 1, ptr = winner+1 (mod FLUX).
//    With none: stay in IDLE.
//  - HOLD: if Eligible(holder) and cnt < BURST, holder wins and cnt++.
//    Otherwise (holder invalid, holder full, or cnt == BURST): release and re-arbitrate in the same
//    cycle as IDLE from ptr. This adds no bubble. Same producer may re-win only if no other is eligible.
//  - BURST = 1 degenerates to pure round-robin, ptr advancing every beat.
//  - Wrap-around: ptr and scan indices use modulo FLUX; correct for non-power-of-2 FLUX.
//  - out_full[i] rising while i holds: transfer stops that cycle; next eligible producer is granted.
//  - All out_full set or no req_valid: out_write = 0; state goes to IDLE; ptr retained.
//  - Reset (rst = 0 at edge): state = IDLE, ptr = 0, holder = 0, cnt = 0. While rst = 0:
//    req_ready = 0, out_write = 0, out_din = 0. Reset mid-burst aborts the burst; no beat is lost,
//    since nothing is consumed while in reset.
// CONFIGURATION
//  FLUX_SCHED_STATS_EN defined:
//    adds output stat_beats [FLUX*16], 16-bit per-flux counters of transferred beats.
//    Counters saturate at 16'hFFFF and are cleared by rst.
//    Also adds stat_stall [FLUX*16]: cycles with req_valid[i] & out_full[i], saturating.
//  Not defined: the ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  flux_sched_pkg: state_t enum {IDLE, HOLD}; function tag_w(flux) returning $clog2;
//    STAT_WIDTH = 16.
//  Sub-module rr_priority_picker #(N): inputs elig[N], ptr; outputs found, idx.
//    Combinational rotate-scan; reused by other multi-flux arbiters.
//  Top holds the FSM, the cnt/ptr registers, the output mux and the optional stats.
// TESTING
//  1 Reset: rst = 0 for 3 cycles with all valid -> req_ready = 0, out_write = 0;
//    first beat after release goes to flux 0.
//  2 All valid, no full, BURST = 4, FLUX = 4 -> tags 0,0,0,0,1,1,1,1,2,...; out_write high every cycle.
//  3 Only flux 2 valid, payload 8'hA5 -> continuous writes, out_din = {2'd2, 8'hA5};
//    quantum expiry causes no gap.
//  4 Flux 1 holding; out_full[1] = 1 at beat 2 -> flux 2 granted the same cycle;
//    flux 1 skipped until full clears.
//  5 FLUX = 3, BURST = 1, all valid -> tags 0,1,2,0,1,2 (modulo wrap); out_full = 3'b111 -> out_write = 0.
//  6 FLUX_SCHED_STATS_EN: 100 beats on flux 3 -> stat_beats[3] = 100;
//    others 0; saturation checked by forcing 16'hFFFE + 3 beats -> 16'hFFFF.

Source files
------------

// File: rtl/flux_sched_pkg.sv
// Shared types and helpers for the flux round-robin scheduler and its picker.
package flux_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int unsigned STAT_WIDTH = 16;

    function automatic int unsigned tag_w(input int unsigned flux);
        return $clog2(flux);
    endfunction

endpackage

// File: rtl/flux_rr_scheduler_if.sv
// Producer-side and datapath-side signals of one shared tagged write port.
interface flux_rr_scheduler_if
    import flux_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FLUX       = 4
);
    localparam int unsigned TAG_WIDTH = tag_w(FLUX);

    logic [FLUX*DATA_WIDTH-1:0]      req_din;
    logic [FLUX-1:0]                 req_valid;
    logic [FLUX-1:0]                 req_ready;
    logic [DATA_WIDTH+TAG_WIDTH-1:0] out_din;
    logic                            out_write;
    logic [FLUX-1:0]                 out_full;

    // Environment side: producers plus the downstream datapath.
    modport master (
        output req_din,
        output req_valid,
        output out_full,
        input  req_ready,
        input  out_din,
        input  out_write
    );

    // Scheduler side.
    modport slave (
        input  req_din,
        input  req_valid,
        input  out_full,
        output req_ready,
        output out_din,
        output out_write
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational rotate-scan: first set bit of elig starting at ptr, wrapping modulo N.
module rr_priority_picker
    import flux_sched_pkg::*;
#(
    parameter  int unsigned N = 4,
    localparam int unsigned W = tag_w(N)
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    int unsigned pos;

    // Scan from the far end back to ptr so the closest candidate is written last.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        pos   = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            pos = 32'(ptr) + 32'(k);
            if (pos >= N) begin
                pos = pos - N;
            end
            if (elig[pos]) begin
                found = 1'b1;
                idx   = W'(pos);
            end
        end
    end

endmodule

// File: rtl/flux_rr_scheduler.sv
// Round-robin scheduler with burst quantum sharing one tagged write port among FLUX producers.
// Optional per-flux beat/stall counters are built when FLUX_SCHED_STATS_EN is defined.
module flux_rr_scheduler
    import flux_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FLUX       = 4,
    parameter int unsigned BURST      = 4
) (
    input logic               clk,
    input logic               rst,
    flux_rr_scheduler_if.slave bus
`ifdef FLUX_SCHED_STATS_EN
    ,
    output logic [FLUX*STAT_WIDTH-1:0] stat_beats,
    output logic [FLUX*STAT_WIDTH-1:0] stat_stall
`endif
);

    localparam int unsigned TAG_WIDTH = tag_w(FLUX);
    localparam logic [7:0]  BURST_CNT = 8'(BURST);

    if (FLUX < 2 || FLUX > 16) begin : g_bad_flux
        $error("FLUX out of range 2..16");
    end
    if (BURST < 1 || BURST > 255) begin : g_bad_burst
        $error("BURST out of range 1..255");
    end

    state_t                 state_q, state_d;
    logic [TAG_WIDTH-1:0]   ptr_q, ptr_d;
    logic [TAG_WIDTH-1:0]   holder_q, holder_d;
    logic [7:0]             cnt_q, cnt_d;

    logic [FLUX-1:0]        elig;
    logic                   pick_found;
    logic [TAG_WIDTH-1:0]   pick_idx;
    logic                   hold_ok;
    logic                   grant;
    logic                   grant_ok;
    logic [TAG_WIDTH-1:0]   winner;
    logic [FLUX-1:0]        ready;
    logic [DATA_WIDTH-1:0]  payload;

    assign elig = bus.req_valid & ~bus.out_full;

    rr_priority_picker #(
        .N(FLUX)
    ) u_picker (
        .elig (elig),
        .ptr  (ptr_q),
        .found(pick_found),
        .idx  (pick_idx)
    );

    // A released holder re-arbitrates in the same cycle, so quantum expiry costs no bubble.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        holder_d = holder_q;
        cnt_d    = cnt_q;
        grant    = 1'b0;
        winner   = holder_q;
        hold_ok  = (state_q == HOLD) && elig[holder_q] && (cnt_q < BURST_CNT);

        if (hold_ok) begin
            grant = 1'b1;
            cnt_d = cnt_q + 8'd1;
        end else if (pick_found) begin
            grant    = 1'b1;
            winner   = pick_idx;
            state_d  = HOLD;
            holder_d = pick_idx;
            cnt_d    = 8'd1;
            if (pick_idx == TAG_WIDTH'(FLUX - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_idx + 1'b1;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            holder_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            holder_q <= holder_d;
            cnt_q    <= cnt_d;
        end
    end

    // Nothing is consumed while reset is asserted.
    assign grant_ok = rst && grant;

    always_comb begin
        ready   = '0;
        payload = '0;
        for (int unsigned i = 0; i < FLUX; i++) begin
            if (winner == TAG_WIDTH'(i)) begin
                ready[i] = grant_ok;
                payload  = bus.req_din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.out_write = grant_ok;
    assign bus.out_din   = grant_ok ? {winner, payload} : '0;

`ifdef FLUX_SCHED_STATS_EN
    for (genvar g = 0; g < FLUX; g++) begin : g_stat
        logic [STAT_WIDTH-1:0] beats_q;
        logic [STAT_WIDTH-1:0] stall_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                beats_q <= '0;
                stall_q <= '0;
            end else begin
                if (ready[g] && (beats_q != '1)) begin
                    beats_q <= beats_q + STAT_WIDTH'(1);
                end
                if (bus.req_valid[g] && bus.out_full[g] && (stall_q != '1)) begin
                    stall_q <= stall_q + STAT_WIDTH'(1);
                end
            end
        end

        assign stat_beats[g*STAT_WIDTH +: STAT_WIDTH] = beats_q;
        assign stat_stall[g*STAT_WIDTH +: STAT_WIDTH] = stall_q;
    end
`endif

endmodule
